srcnn_sdiv_32s_16ns_16s_seq: RTL and testbench
==============================================

// Module: srcnn_sdiv_32s_16ns_16s_seq
// PURPOSE
//  Sequential divider that undoes the 16ns x 16s -> 32-bit product used by the SRCNN conv datapath.
//  Takes a signed 32-bit product/accumulator and an unsigned 16-bit divisor (scale/normaliser).
//  Returns a saturated signed 16-bit quotient plus remainder and status flags.
//  Sits after the accumulator in the rescale stage; one divide in flight, valid/ready on both sides.
// PARAMETERS
//  ID          1    instance tag, no functional effect
//  DIVD_WIDTH  32   dividend width (signed)
//  DIVS_WIDTH  16   divisor width (unsigned)
//  QUO_WIDTH   16   quotient output width (signed, saturated)
// PORTS
//  ap_clk      in   1    clock, rising edge
//  ap_rst      in   1    reset, asynchronous, active-high
//  in_valid    in   1    dividend/divisor present
//  in_ready    out  1    block can accept (high only in IDLE)
//  din0        in   32   dividend, signed
//  din1        in   16   divisor, unsigned
//  out_valid   out  1    result present
//  out_ready   in   1    consumer accepts result
//  quot        out  16   quotient, signed, truncated toward zero, saturated
//  rem         out  17   remainder, signed, sign follows dividend, |rem| < din1
//  ovf         out  1    quotient saturated
//  dbz         out  1    divisor was zero
// BEHAVIOUR
//  - One clock, ap_clk; ap_rst asynchronous active-high. Reset: state=IDLE, in_ready=1 after release, out_valid=0, quot=0, rem=0, ovf=0, dbz=0.
//  - States IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE: in_ready=1; on in_valid&&in_ready, latch sign(din0), |din0| as 32-bit unsigned (handles -2^31), din1; count=31.
//    -> CALC if din1!=0, else -> FIX with dbz set.
//  - CALC: one restoring step per cycle, MSB first: partial = {partial[15:0], mag[count]}.
//    If partial >= divisor: subtract and set quotient bit. Partial remainder is 17 bits, quotient register 32 bits.
//    Exactly 32 cycles; count==0 -> FIX.
//  - FIX (1 cycle):
//    - Apply sign: q negated if signs differ (divisor always positive, so if dividend negative); rem negated if dividend negative.
//    - Saturate: q > 32767 -> 32767, ovf=1; q < -32768 -> -32768, ovf=1.
//    - dbz: quot = 32767 if dividend >= 0, else -32768; rem = 0; ovf = 0.
//  - DONE: out_valid=1; quot/rem/ovf/dbz stable until out_valid&&out_ready -> IDLE.
//    Outputs hold their last values in IDLE and are overwritten only in FIX.
//  - Latency: accept edge at cycle 0 -> out_valid high from cycle 34 (dbz: cycle 2). Throughput: one op per >=35 cycles (dbz >=3).
//  - in_ready is 0 during CALC/FIX/DONE; no accept in the cycle of the out handshake (in_ready rises the next cycle).
//  - in_valid/data during busy states are ignored (not latched).
//  - ap_rst mid-operation: immediate abort to reset values, no partial result emitted.
//  - Exact quotient -32768 (e.g. -65536/2) is not overflow.
// STRUCTURE
//  - Package srcnn_div_pkg: state encoding (IDLE, CALC, FIX, DONE), DIVD_W/DIVS_W/QUO_W/REM_W constants.
//    Also Q_MAX=16'sh7FFF and Q_MIN=16'sh8000 constants.
//  - One sub-module srcnn_udiv_step: combinational restoring step
//    (17-bit partial, 16-bit divisor, next bit) -> (new partial, quotient bit).
//  - Top holds FSM, 5-bit counter, magnitude/quotient shift registers, sign/saturate logic.
// TESTING
//  - 1000 / 7 -> quot=142, rem=6, ovf=0, dbz=0, out_valid exactly 34 cycles after accept.
//  - -1000 / 7 -> quot=-142, rem=-6.
//  - 0x7FFFFFFF / 1 -> quot=32767, ovf=1.
//  - -2^31 / 65535 -> quot=-32768, rem=-32768, ovf=0.
//  - 5 / 0 -> quot=32767, dbz=1, rem=0, out_valid 2 cycles after accept.
//  - Same op with -5 / 0 -> quot=-32768, dbz=1.
//  - Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, second in_valid ignored.
//    Release -> in_ready high next cycle.
//  - Assert ap_rst at cycle 12 of CALC -> out_valid=0 immediately, in_ready=1 after release.
//    A fresh 100/10 then returns quot=10, rem=0.

Source files
------------

// File: rtl/srcnn_div_pkg.sv
// Shared constants and state encoding for the SRCNN rescale divider.
package srcnn_div_pkg;

  localparam int DIVD_W = 32;
  localparam int DIVS_W = 16;
  localparam int QUO_W  = 16;
  localparam int REM_W  = DIVS_W + 1;

  localparam logic [QUO_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic [QUO_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_t;

endpackage

// File: rtl/srcnn_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module srcnn_udiv_step
  import srcnn_div_pkg::*;
(
  input  logic [REM_W-1:0]  part_in,
  input  logic [DIVS_W-1:0] divisor,
  input  logic              bit_in,
  output logic [REM_W-1:0]  part_out,
  output logic              q_bit
);

  // One extra bit so the shifted value never wraps; the incoming partial is always < divisor.
  logic [REM_W:0] shifted;
  logic [REM_W:0] diff;

  always_comb begin
    shifted  = {part_in, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = (shifted >= {2'b00, divisor});
    part_out = q_bit ? diff[REM_W-1:0] : shifted[REM_W-1:0];
  end

endmodule

// File: rtl/srcnn_sdiv_32s_16ns_16s_seq.sv
// Signed 32-bit by unsigned 16-bit sequential divider with saturated 16-bit quotient.
module srcnn_sdiv_32s_16ns_16s_seq
  import srcnn_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIVD_WIDTH = 32,
  parameter int DIVS_WIDTH = 16,
  parameter int QUO_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVD_WIDTH-1:0] din0,
  input  logic [DIVS_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUO_WIDTH-1:0]  quot,
  output logic [DIVS_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dbz
);

  state_t             state_q;
  logic [4:0]         count_q;
  logic [DIVD_W-1:0]  mag_q;
  logic [DIVD_W-1:0]  qreg_q;
  logic [DIVS_W-1:0]  divs_q;
  logic [REM_W-1:0]   part_q;
  logic               neg_q;
  logic               zdiv_q;

  logic [REM_W-1:0]   step_part;
  logic               step_q;
  logic               q_hi;
  logic               sat_ovf;
  logic [QUO_W-1:0]   sat_quot;
  logic [REM_W-1:0]   signed_rem;

  srcnn_udiv_step u_step (
    .part_in  (part_q),
    .divisor  (divs_q),
    .bit_in   (mag_q[count_q]),
    .part_out (step_part),
    .q_bit    (step_q)
  );

  assign in_ready = (state_q == StIdle);

  // Saturation works on the unsigned magnitude: a negative result may reach 32768.
  always_comb begin
    q_hi       = |qreg_q[DIVD_W-1:QUO_W];
    sat_ovf    = 1'b0;
    sat_quot   = '0;
    signed_rem = neg_q ? (~part_q + 1'b1) : part_q;
    if (neg_q) begin
      sat_ovf  = q_hi | (qreg_q[QUO_W-1] & (|qreg_q[QUO_W-2:0]));
      sat_quot = sat_ovf ? Q_MIN : (~qreg_q[QUO_W-1:0] + 1'b1);
    end else begin
      sat_ovf  = q_hi | qreg_q[QUO_W-1];
      sat_quot = sat_ovf ? Q_MAX : qreg_q[QUO_W-1:0];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mag_q     <= '0;
      qreg_q    <= '0;
      divs_q    <= '0;
      part_q    <= '0;
      neg_q     <= 1'b0;
      zdiv_q    <= 1'b0;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            neg_q   <= din0[DIVD_W-1];
            mag_q   <= din0[DIVD_W-1] ? (~din0 + 1'b1) : din0;
            divs_q  <= din1;
            count_q <= 5'd31;
            part_q  <= '0;
            qreg_q  <= '0;
            zdiv_q  <= (din1 == '0);
            state_q <= (din1 == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          part_q  <= step_part;
          qreg_q  <= {qreg_q[DIVD_W-2:0], step_q};
          count_q <= count_q - 5'd1;
          if (count_q == 5'd0) state_q <= StFix;
        end
        StFix: begin
          if (zdiv_q) begin
            quot <= neg_q ? Q_MIN : Q_MAX;
            rem  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b1;
          end else begin
            quot <= sat_quot;
            rem  <= signed_rem;
            ovf  <= sat_ovf;
            dbz  <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_srcnn_sdiv_32s_16ns_16s_seq.sv
// Directed bench for the SRCNN sequential divider: results, latency, hold-off and reset abort.
module tb_srcnn_sdiv_32s_16ns_16s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din0 = '0;
  logic [15:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [16:0] rem;
  logic        ovf;
  logic        dbz;

  int total = 0;
  int bad = 0;

  always #5 ap_clk = ~ap_clk;

  srcnn_sdiv_32s_16ns_16s_seq u_dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic chk(input string tag, input integer obs, input integer exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Latency = index of the first edge (accept edge = 0) that sees out_valid high.
  task automatic wait_result(output integer lat);
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge ap_clk);
      if (out_valid === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic accept(input string name, input logic [31:0] a, input logic [15:0] b);
    @(negedge ap_clk);
    chk({name, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1 out_ready = 1'b0;
    chk({name, ".out_valid_drop"}, out_valid, 0);
    chk({name, ".in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [15:0] b,
                        input integer elat, input integer eq, input integer er,
                        input integer eovf, input integer edbz);
    integer lat;
    accept(name, a, b);
    wait_result(lat);
    chk({name, ".latency"}, lat, elat);
    chk({name, ".quot"}, $signed(quot), eq);
    chk({name, ".rem"}, $signed(rem), er);
    chk({name, ".ovf"}, ovf, eovf);
    chk({name, ".dbz"}, dbz, edbz);
    handshake(name);
  endtask

  initial begin
    integer lat;

    // Reset state, checked while reset is held.
    #2 ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.quot", $signed(quot), 0);
    chk("rst.rem", $signed(rem), 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.dbz", dbz, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst.in_ready", in_ready, 1);

    run_op("pos",      32'd1000,           16'd7,     34,    142,      6, 0, 0);
    run_op("neg",      -32'sd1000,         16'd7,     34,   -142,     -6, 0, 0);
    run_op("pos_sat",  32'h7FFF_FFFF,      16'd1,     34,  32767,      0, 1, 0);
    run_op("min_div",  32'h8000_0000,      16'd65535, 34, -32768, -32768, 0, 0);
    run_op("dbz_pos",  32'd5,              16'd0,      2,  32767,      0, 0, 1);
    run_op("dbz_neg",  -32'sd5,            16'd0,      2, -32768,      0, 0, 1);
    run_op("exact_min", -32'sd65536,       16'd2,     34, -32768,      0, 0, 0);
    run_op("pos_edge", 32'd65536,          16'd2,     34,  32767,      0, 1, 0);
    run_op("neg_sat",  -32'sd100000,       16'd3,     34, -32768,     -1, 1, 0);
    run_op("pos_big",  32'd100000,         16'd3,     34,  32767,      1, 1, 0);

    // Consumer stalls for 10 cycles while a new request is offered and must be ignored.
    accept("hold", 32'd300, 16'd7);
    wait_result(lat);
    chk("hold.latency", lat, 34);
    in_valid = 1'b1;
    din0 = 32'd12345;
    din1 = 16'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("hold.out_valid", out_valid, 1);
      chk("hold.in_ready", in_ready, 0);
      chk("hold.quot", $signed(quot), 42);
      chk("hold.rem", $signed(rem), 6);
    end
    in_valid = 1'b0;
    handshake("hold");
    chk("hold.quot_after", $signed(quot), 42);

    // Abort mid-calculation: results reset, nothing emitted, block usable again.
    accept("abort", 32'd1000, 16'd7);
    repeat (11) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.quot", $signed(quot), 0);
    chk("abort.rem", $signed(rem), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    chk("abort.in_ready", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      chk("abort.no_result", out_valid, 0);
    end
    run_op("fresh", 32'd100, 16'd10, 34, 10, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
